// File: rtl/clint_ahb_bridge.sv
// rtl/clint_ahb_bridge.sv - AHB-Lite subordinate driving CLINT register selects and strobes.
// Optional ERROR response path for illegal transfers: define CLINT_BRIDGE_ERR_EN.
module clint_ahb_bridge #(
  parameter int OFFS_W = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        msip_sel,
  output logic        mtimecmp_sel,
  output logic        mtimecmph_sel,
  output logic        mtime_sel,
  output logic        mtimeh_sel,
  output logic        wen,
  output logic        ren,
  output logic [31:0] wdata,
  output logic [31:0] addr,
  input  logic [31:0] rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_DONE, ERR1, ERR2} state_t;

  state_t      state_q;
  logic [4:0]  sel_q;
  logic [4:0]  sel_d;
  logic        wen_q;
  logic        ren_q;
  logic        hreadyout_q;
  logic        hresp_q;
  logic [31:0] hrdata_q;
  logic [31:0] addr_q;
  logic        accept;
  logic        legal;
  logic        unused_htrans0;

  logic [OFFS_W-1:0] offs;

  assign offs           = HADDR[OFFS_W-1:0];
  assign accept         = HSEL & HREADY & HTRANS[1];
  assign unused_htrans0 = HTRANS[0];

  // sel_d bit order: msip, mtimecmp, mtimecmph, mtime, mtimeh
  always_comb begin
    sel_d = 5'b0;
    if (offs == OFFS_W'(32'h0000)) sel_d[0] = 1'b1;
    if (offs == OFFS_W'(32'h4000)) sel_d[1] = 1'b1;
    if (offs == OFFS_W'(32'h4004)) sel_d[2] = 1'b1;
    if (offs == OFFS_W'(32'hBFF8)) sel_d[3] = 1'b1;
    if (offs == OFFS_W'(32'hBFFC)) sel_d[4] = 1'b1;
  end

  assign legal = (|sel_d) && (HADDR[1:0] == 2'b00) && (HSIZE == 3'b010);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      sel_q       <= 5'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0;
      addr_q      <= 32'h0;
    end else begin
      case (state_q)
        RD_WAIT: begin
          hrdata_q    <= rdata;
          sel_q       <= 5'b0;
          ren_q       <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          state_q     <= RD_DONE;
        end
        ERR1: begin
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
          state_q     <= ERR2;
        end
        default: begin
          // IDLE, WR, RD_DONE and ERR2 all complete with HREADYOUT high, so they accept
          sel_q       <= 5'b0;
          wen_q       <= 1'b0;
          ren_q       <= 1'b0;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          state_q     <= IDLE;
          if (accept) begin
            addr_q <= HADDR;
            if (legal) begin
              sel_q <= sel_d;
              if (HWRITE) begin
                wen_q   <= 1'b1;
                state_q <= WR;
              end else begin
                ren_q       <= 1'b1;
                hreadyout_q <= 1'b0;
                state_q     <= RD_WAIT;
              end
            end else begin
`ifdef CLINT_BRIDGE_ERR_EN
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
              state_q     <= ERR1;
`else
              if (!HWRITE) hrdata_q <= 32'h0;
`endif
            end
          end
        end
      endcase
    end
  end

  assign msip_sel      = sel_q[0];
  assign mtimecmp_sel  = sel_q[1];
  assign mtimecmph_sel = sel_q[2];
  assign mtime_sel     = sel_q[3];
  assign mtimeh_sel    = sel_q[4];
  assign wen           = wen_q;
  assign ren           = ren_q;
  assign wdata         = wen_q ? HWDATA : 32'h0;
  assign addr          = addr_q;
  assign HRDATA        = hrdata_q;
  assign HREADYOUT     = hreadyout_q;
  assign HRESP         = hresp_q;

endmodule

// File: tb/tb_clint_ahb_bridge.sv
// tb/tb_clint_ahb_bridge.sv - directed vector bench for clint_ahb_bridge.
module tb_clint_ahb_bridge;

`ifdef CLINT_BRIDGE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        msip_sel, mtimecmp_sel, mtimecmph_sel, mtime_sel, mtimeh_sel;
  logic        wen, ren;
  logic [31:0] wdata;
  logic [31:0] addr;
  logic [31:0] rdata;

  int tests_run = 0;
  int tests_failed = 0;

  clint_ahb_bridge #(.OFFS_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .msip_sel(msip_sel), .mtimecmp_sel(mtimecmp_sel), .mtimecmph_sel(mtimecmph_sel),
    .mtime_sel(mtime_sel), .mtimeh_sel(mtimeh_sel),
    .wen(wen), .ren(ren), .wdata(wdata), .addr(addr), .rdata(rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [4:0]  sel;
    logic        xwen;
    logic        xren;
    logic [31:0] xwdata;
    logic        hro1;
    logic        resp1;
    logic        resp2;
    logic        chk_rd;
    logic [31:0] xrdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd,
                              logic [31:0] rd, logic [4:0] sel, logic xwen, logic xren,
                              logic [31:0] xwdata, logic hro1, logic resp1, logic resp2,
                              logic chk_rd, logic [31:0] xrdata);
    vec_t v;
    v.wr = wr; v.a = a; v.sz = sz; v.wd = wd; v.rd = rd; v.sel = sel;
    v.xwen = xwen; v.xren = xren; v.xwdata = xwdata; v.hro1 = hro1;
    v.resp1 = resp1; v.resp2 = resp2; v.chk_rd = chk_rd; v.xrdata = xrdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] sels();
    return {mtimeh_sel, mtime_sel, mtimecmph_sel, mtimecmp_sel, msip_sel};
  endfunction

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
    HADDR = 32'h0; HREADY = 1'b1;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz; HREADY = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    addr_phase(v.wr, v.a, v.sz);
    @(posedge CLK); #1;
    bus_idle();
    HWDATA = v.wd;
    rdata  = v.rd;
    #1;
    check({p, ".sel"}, 32'(sels()), 32'(v.sel));
    check({p, ".wen"}, 32'(wen), 32'(v.xwen));
    check({p, ".ren"}, 32'(ren), 32'(v.xren));
    check({p, ".wdata"}, wdata, v.xwdata);
    check({p, ".hreadyout1"}, 32'(HREADYOUT), 32'(v.hro1));
    check({p, ".hresp1"}, 32'(HRESP), 32'(v.resp1));
    check({p, ".addr"}, addr, v.a);
    @(posedge CLK); #2;
    check({p, ".sel2"}, 32'(sels()), 32'h0);
    check({p, ".strobe2"}, 32'({wen, ren}), 32'h0);
    check({p, ".hreadyout2"}, 32'(HREADYOUT), 32'h1);
    check({p, ".hresp2"}, 32'(HRESP), 32'(v.resp2));
    if (v.chk_rd) check({p, ".hrdata"}, HRDATA, v.xrdata);
    @(posedge CLK); #1;
  endtask

  initial begin
    vecs[0] = mk(1, 32'h0000_0000, 3'b010, 32'h0000_0001, 32'h0, 5'b00001, 1, 0, 32'h0000_0001, 1, 0, 0, 0, 32'h0);
    vecs[1] = mk(0, 32'h0000_BFF8, 3'b010, 32'h0, 32'h1234_5678, 5'b01000, 0, 1, 32'h0, 0, 0, 0, 1, 32'h1234_5678);
    vecs[2] = mk(1, 32'h0000_4000, 3'b010, 32'hAAAA_5555, 32'h0, 5'b00010, 1, 0, 32'hAAAA_5555, 1, 0, 0, 0, 32'h0);
    vecs[3] = mk(0, 32'h0000_BFFC, 3'b010, 32'h0, 32'hDEAD_BEEF, 5'b10000, 0, 1, 32'h0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    vecs[4] = mk(0, 32'h0200_4004, 3'b010, 32'h0, 32'h0BAD_F00D, 5'b00100, 0, 1, 32'h0, 0, 0, 0, 1, 32'h0BAD_F00D);
    vecs[5] = mk(0, 32'h0000_0010, 3'b010, 32'h0, 32'hFFFF_FFFF, 5'b0, 0, 0, 32'h0, !ERR, ERR, ERR, !ERR, 32'h0);
    vecs[6] = mk(1, 32'h0000_4000, 3'b001, 32'h0000_1234, 32'h0, 5'b0, 0, 0, 32'h0, !ERR, ERR, ERR, 0, 32'h0);
    vecs[7] = mk(1, 32'h0000_4002, 3'b010, 32'h0000_5678, 32'h0, 5'b0, 0, 0, 32'h0, !ERR, ERR, ERR, 0, 32'h0);
    vecs[8] = mk(0, 32'h0000_0000, 3'b010, 32'h0, 32'h0000_0001, 5'b00001, 0, 1, 32'h0, 0, 0, 0, 1, 32'h0000_0001);
    vecs[9] = mk(0, 32'h0000_BFF8, 3'b000, 32'h0, 32'hCAFE_0001, 5'b0, 0, 0, 32'h0, !ERR, ERR, ERR, !ERR, 32'h0);

    bus_idle();
    HWDATA = 32'h0;
    rdata  = 32'h0;
    nRST   = 1'b1;
    #1 nRST = 1'b0;
    #2;
    check("rst.hrdata", HRDATA, 32'h0);
    check("rst.addr", addr, 32'h0);
    check("rst.sel", 32'(sels()), 32'h0);
    check("rst.strobes", 32'({wen, ren}), 32'h0);
    check("rst.wdata", wdata, 32'h0);
    check("rst.hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst.hresp", 32'(HRESP), 32'h0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // back-to-back writes: mtimecmp then mtimecmph with no bubble
    addr_phase(1, 32'h0000_4000, 3'b010);
    @(posedge CLK); #1;
    addr_phase(1, 32'h0000_4004, 3'b010);
    HWDATA = 32'h0000_0011;
    #1;
    check("b2b.sel1", 32'(sels()), 32'h2);
    check("b2b.wen1", 32'(wen), 32'h1);
    check("b2b.wdata1", wdata, 32'h0000_0011);
    @(posedge CLK); #1;
    bus_idle();
    HWDATA = 32'h0000_0022;
    #1;
    check("b2b.sel2", 32'(sels()), 32'h4);
    check("b2b.wen2", 32'(wen), 32'h1);
    check("b2b.wdata2", wdata, 32'h0000_0022);
    @(posedge CLK); #2;
    check("b2b.sel3", 32'(sels()), 32'h0);
    check("b2b.wen3", 32'(wen), 32'h0);
    check("b2b.wdata3", wdata, 32'h0);

    // reset asserted while a read is waiting
    addr_phase(0, 32'h0000_BFF8, 3'b010);
    @(posedge CLK); #1;
    bus_idle();
    rdata = 32'h5555_AAAA;
    #1;
    check("rstrd.ren_before", 32'(ren), 32'h1);
    check("rstrd.hro_before", 32'(HREADYOUT), 32'h0);
    nRST = 1'b0;
    #1;
    check("rstrd.ren", 32'(ren), 32'h0);
    check("rstrd.sel", 32'(sels()), 32'h0);
    check("rstrd.hreadyout", 32'(HREADYOUT), 32'h1);
    check("rstrd.hrdata", HRDATA, 32'h0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #2;
    check("rstrd.after_strobes", 32'({wen, ren, sels()}), 32'h0);
    check("rstrd.after_hro", 32'(HREADYOUT), 32'h1);
    check("rstrd.after_hrdata", HRDATA, 32'h0);

    // BUSY with HSEL, NONSEQ without HSEL, NONSEQ with HREADY low: none accepted
    addr_phase(1, 32'h0000_0000, 3'b010);
    HTRANS = 2'b01;
    @(posedge CLK); #1;
    bus_idle();
    #1;
    check("busy.strobes", 32'({wen, ren, sels()}), 32'h0);
    check("busy.hreadyout", 32'(HREADYOUT), 32'h1);
    check("busy.hresp", 32'(HRESP), 32'h0);
    addr_phase(1, 32'h0000_4000, 3'b010);
    HSEL = 1'b0;
    @(posedge CLK); #1;
    bus_idle();
    #1;
    check("nosel.strobes", 32'({wen, ren, sels()}), 32'h0);
    check("nosel.hreadyout", 32'(HREADYOUT), 32'h1);
    addr_phase(0, 32'h0000_BFF8, 3'b010);
    HREADY = 1'b0;
    @(posedge CLK); #1;
    bus_idle();
    #1;
    check("nordy.strobes", 32'({wen, ren, sels()}), 32'h0);
    check("nordy.hreadyout", 32'(HREADYOUT), 32'h1);
    @(posedge CLK); #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clint_ahb_bridge.md
# clint_ahb_bridge

Bus-side initiator for the core-local interruptor. Accepts AHB-Lite subordinate transfers from the system bus, decodes the word offset into one-hot CLINT register selects, and drives the `clint_if` `top` modport signals (`*_sel`, `wen`, `ren`, `wdata`, `addr`). Returns CLINT read data on `HRDATA` with one wait state. Sits between the AHB interconnect and the CLINT; the interrupt outputs bypass this block.

## Interface
- `OFFS_W`, default 16: number of low `HADDR` bits decoded; upper bits are qualified by `HSEL` only.
- `CLK`  in  1  system clock, rising edge
- `nRST`  in  1  asynchronous, active-low reset
- `HSEL`  in  1  subordinate select
- `HADDR`  in  32  transfer address
- `HTRANS`  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- `HWRITE`  in  1  1 = write
- `HSIZE`  in  3  transfer size; only 3'b010 (word) is legal
- `HWDATA`  in  32  write data, valid in the data phase
- `HREADY`  in  1  bus-wide ready
- `HRDATA`  out  32  registered read data
- `HREADYOUT`  out  1  subordinate ready
- `HRESP`  out  1  1 = ERROR
- `msip_sel`, `mtimecmp_sel`, `mtimecmph_sel`, `mtime_sel`, `mtimeh_sel`  out  1 each  one-hot register select to the CLINT
- `wen` / `ren`  out  1 each  write / read strobe to the CLINT
- `wdata`  out  32  equals `HWDATA` while `wen` = 1, else 0
- `addr`  out  32  registered address-phase `HADDR`
- `rdata`  in  32  CLINT read data, combinational from the selects

## Operation
- Address phase is accepted when `HSEL & HREADY & HTRANS[1]`. On accept, register `HADDR`, `HWRITE` and the decode result.
- Offset decode on `HADDR[OFFS_W-1:0]`:
  - 0x0000 → msip
  - 0x4000 → mtimecmp
  - 0x4004 → mtimecmph
  - 0xBFF8 → mtime
  - 0xBFFC → mtimeh
  - Anything else, `HADDR[1:0]` ≠ 0, or `HSIZE` ≠ word is illegal.
- FSM states: IDLE, WR, RD_WAIT, RD_DONE, ERR1, ERR2.
  - IDLE/WR/RD_DONE with a legal write accepted → WR.
  - Legal read accepted → RD_WAIT.
  - Illegal transfer accepted → ERR1.
  - No accept → IDLE.
  - RD_WAIT → RD_DONE unconditionally.
  - ERR1 → ERR2 unconditionally.
  - ERR2 follows the IDLE rules; this is a normal accept cycle because `HREADYOUT` = 1.
- WR: selected `*_sel` = 1, `wen` = 1, `wdata` = `HWDATA`, `HREADYOUT` = 1.
- RD_WAIT: selected `*_sel` = 1, `ren` = 1, `HREADYOUT` = 0. `rdata` is registered into `HRDATA` at the end of the cycle.
- RD_DONE: no strobes, `HREADYOUT` = 1, `HRDATA` held.
- ERR1: `HREADYOUT` = 0, `HRESP` = 1.
- ERR2: `HREADYOUT` = 1, `HRESP` = 1.
- At most one `*_sel` is high in any cycle. `wen` and `ren` are never both high.
- In all other states, all strobes are 0 and `HRESP` = 0.

## Timing
- Reset values:
  - FSM = IDLE
  - `HRDATA` = 0, `addr` = 0
  - all `*_sel`, `wen`, `ren` = 0, `wdata` = 0
  - `HREADYOUT` = 1, `HRESP` = 0
- Write latency: 0 wait states. Strobes are high in the single data-phase cycle (N+1 for an address phase in cycle N).
- Read latency: 1 wait state. Strobes are high in N+1; `HRDATA` is valid with `HREADYOUT` = 1 in N+2.
- Back-to-back writes: a new address phase is accepted in the WR cycle, giving one write strobe per cycle.
- No address phase is accepted while `HREADYOUT` = 0 (RD_WAIT, ERR1), because `HREADY` is low bus-wide.
- IDLE/BUSY `HTRANS`, or `HSEL` = 0: OKAY response, zero wait, no strobes.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous). A pending read is dropped with no strobe after reset.

## Configuration
- `CLINT_BRIDGE_ERR_EN` defined: illegal transfers take the two-cycle ERROR path (ERR1/ERR2).
- Not defined: illegal transfers complete as OKAY with zero wait states and no CLINT strobes. Reads return `HRDATA` = 0; writes are discarded. ERR1/ERR2 are unreachable.

## Test plan
- Write 0x0000_0001 to offset 0x0000 → `msip_sel` = `wen` = 1 and `wdata` = 0x1 for exactly one cycle; `HREADYOUT` stays 1.
- Read offset 0xBFF8 with CLINT `rdata` = 0x1234_5678 → `mtime_sel` = `ren` = 1 in N+1 with `HREADYOUT` = 0; `HRDATA` = 0x1234_5678 with `HREADYOUT` = 1 in N+2.
- Back-to-back writes to 0x4000 then 0x4004 → `mtimecmp_sel` in N+1 and `mtimecmph_sel` in N+2, no bubble.
- Read of offset 0x0010 or a halfword write to 0x4000:
  - with `CLINT_BRIDGE_ERR_EN`: `HRESP` = 1 for 2 cycles, `HREADYOUT` = 0 then 1, no strobes;
  - without it: OKAY, `HRDATA` = 0, no strobes.
- `nRST` pulsed low during RD_WAIT → strobes drop the same cycle, `HREADYOUT` = 1, `HRDATA` = 0; FSM is in IDLE after release.
- `HTRANS` = BUSY with `HSEL` = 1 → no strobes, `HREADYOUT` = 1, `HRESP` = 0.
